pc_predict_unit: RTL and testbench

Parametrised fetch-stage PC generator that succeeds the basic PC mux/register pair. It holds the program counter and supports pipeline stall and execute-stage redirect. It predicts the next PC with an internal direct-mapped branch target buffer (BTB) using 2-bit saturating counters. The BTB is trained by the execute stage through an update port. The block sits at the front of the 5-stage pipeline, driving instruction-memory address and the F/D pipeline register.

---
 rtl/pc_predict_unit.sv | 130 +++++++++++++
 tb/tb_pc_predict_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator with stall/redirect control and a direct-mapped
// BTB of 2-bit saturating counters that is trained from the execute stage.
module pc_predict_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int               BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = WIDTH - IDX_W - 2;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic             valid_r  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_r    [BTB_DEPTH];
    logic [WIDTH-1:0] target_r [BTB_DEPTH];
    logic [1:0]       ctr_r    [BTB_DEPTH];

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] next_pc_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             hit_s;
    logic             pred_taken_s;
    logic [WIDTH-1:0] pred_target_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             upd_hit_s;
    logic             unused_upd_lsb_s;

    assign pc_plus4_s       = pc_r + WIDTH'(3'd4);
    assign idx_s            = pc_r[IDX_W+1:2];
    assign tag_s            = pc_r[WIDTH-1:IDX_W+2];
    assign upd_idx_s        = upd_pc[IDX_W+1:2];
    assign upd_tag_s        = upd_pc[WIDTH-1:IDX_W+2];
    assign unused_upd_lsb_s = ^upd_pc[1:0];

    // Lookup reads the registered PC only, so update data never reaches the outputs combinationally.
    always_comb begin
        hit_s         = 1'b0;
        pred_taken_s  = 1'b0;
        pred_target_s = pc_plus4_s;
        upd_hit_s     = 1'b0;
        hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        if (hit_s) begin
            pred_taken_s  = ctr_r[idx_s][1];
            pred_target_s = target_r[idx_s];
        end else begin
            pred_taken_s  = 1'b0;
            pred_target_s = pc_plus4_s;
        end
    end

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (redirect) begin
            next_pc_s = redirect_target;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else if (pred_taken_s) begin
            next_pc_s = pred_target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // BTB training; writes land after this edge's lookup, giving write-after-read ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= 2'b00;
            end
        end else if (upd_en) begin
            if (upd_hit_s) begin
                if (upd_taken) begin
                    ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= upd_target;
                end else begin
                    ctr_r[upd_idx_s] <= ctr_dec(ctr_r[upd_idx_s]);
                end
            end else if (upd_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= upd_target;
                ctr_r[upd_idx_s]    <= 2'b10;
            end
        end
    end

    assign PC          = pc_r;
    assign PCPlus4     = pc_plus4_s;
    assign pred_taken  = pred_taken_s;
    assign pred_target = pred_target_s;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed self-checking bench for pc_predict_unit (RESET_PC=0x100, 16-entry BTB).
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        pred_taken;
    logic [31:0] pred_target;

    int tests_run = 0;
    int failed    = 0;

    pc_predict_unit #(.WIDTH(32), .RESET_PC(32'h0000_0100), .BTB_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .PC(PC),
        .PCPlus4(PCPlus4), .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        redirect        = 1'b1;
        redirect_target = addr;
        step();
        redirect        = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        step();
        upd_en     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests_run++; if (PC !== 32'h100) begin failed++; $display("FAIL reset_pc got %h exp %h", PC, 32'h100); end
        tests_run++; if (PCPlus4 !== 32'h104) begin failed++; $display("FAIL reset_pcplus4 got %h exp %h", PCPlus4, 32'h104); end
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++; if (PC !== 32'h100 + 32'(4 * i)) begin failed++; $display("FAIL seq_pc[%0d] got %h exp %h", i, PC, 32'h100 + 32'(4 * i)); end
            tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL seq_pred[%0d] got %b exp 0", i, pred_taken); end
        end
    endtask

    task automatic test_stall_redirect();
        go_to(32'h10);
        tests_run++; if (PC !== 32'h10) begin failed++; $display("FAIL redirect_pc got %h exp %h", PC, 32'h10); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (PC !== 32'h10) begin failed++; $display("FAIL stall_hold[%0d] got %h exp %h", i, PC, 32'h10); end
        end
        go_to(32'h200);
        tests_run++; if (PC !== 32'h200) begin failed++; $display("FAIL redirect_over_stall got %h exp %h", PC, 32'h200); end
        stall = 1'b0;
    endtask

    task automatic test_allocate();
        train(32'h20, 32'h80, 1'b1);
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL alloc_pred got %b exp 1", pred_taken); end
        tests_run++; if (pred_target !== 32'h80) begin failed++; $display("FAIL alloc_target got %h exp %h", pred_target, 32'h80); end
        step();
        tests_run++; if (PC !== 32'h80) begin failed++; $display("FAIL alloc_follow got %h exp %h", PC, 32'h80); end
    endtask

    task automatic test_hysteresis();
        train(32'h20, 32'h80, 1'b0);                                   // 10 -> 01
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL hyst_01 got %b exp 0", pred_taken); end
        tests_run++; if (pred_target !== 32'h80) begin failed++; $display("FAIL hyst_01_target got %h exp %h", pred_target, 32'h80); end
        step();
        tests_run++; if (PC !== 32'h24) begin failed++; $display("FAIL hyst_fallthrough got %h exp %h", PC, 32'h24); end
        train(32'h20, 32'h80, 1'b1); train(32'h20, 32'h80, 1'b1);      // -> 11
        train(32'h20, 32'h80, 1'b0);                                   // -> 10
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL hyst_10 got %b exp 1", pred_taken); end
        train(32'h20, 32'h80, 1'b1); train(32'h20, 32'h80, 1'b1);
        train(32'h20, 32'h80, 1'b1);                                   // saturates at 11
        train(32'h20, 32'h80, 1'b0);                                   // -> 10
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL hyst_sat_high got %b exp 1", pred_taken); end
        train(32'h20, 32'h80, 1'b0); train(32'h20, 32'h80, 1'b0);
        train(32'h20, 32'h80, 1'b0);                                   // 01, 00, 00
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL hyst_sat_low got %b exp 0", pred_taken); end
        train(32'h20, 32'h80, 1'b1);                                   // -> 01
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL hyst_00_to_01 got %b exp 0", pred_taken); end
    endtask

    task automatic test_alias();
        train(32'h20, 32'h80, 1'b1);                                   // 01 -> 10
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL alias_base got %b exp 1", pred_taken); end
        go_to(32'h60);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL alias_nohit got %b exp 0", pred_taken); end
        train(32'h60, 32'h300, 1'b1);
        go_to(32'h60);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL alias_evict_pred got %b exp 1", pred_taken); end
        tests_run++; if (pred_target !== 32'h300) begin failed++; $display("FAIL alias_evict_target got %h exp %h", pred_target, 32'h300); end
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL alias_old_miss got %b exp 0", pred_taken); end
        tests_run++; if (pred_target !== 32'h24) begin failed++; $display("FAIL alias_miss_target got %h exp %h", pred_target, 32'h24); end
    endtask

    task automatic test_back_to_back();
        go_to(32'h40);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL same_cycle_pre got %b exp 0", pred_taken); end
        train(32'h40, 32'h500, 1'b1);
        tests_run++; if (PC !== 32'h44) begin failed++; $display("FAIL same_cycle_pc got %h exp %h", PC, 32'h44); end
        go_to(32'h40);
        tests_run++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL revisit_pred got %b exp 1", pred_taken); end
        tests_run++; if (pred_target !== 32'h500) begin failed++; $display("FAIL revisit_target got %h exp %h", pred_target, 32'h500); end
        stall = 1'b1;
        train(32'h8, 32'h600, 1'b1);
        stall = 1'b0;
        go_to(32'h8);
        tests_run++; if (pred_target !== 32'h600) begin failed++; $display("FAIL update_under_stall got %h exp %h", pred_target, 32'h600); end
    endtask

    task automatic test_wrap_and_reset();
        go_to(32'hFFFF_FFFC);
        tests_run++; if (PCPlus4 !== 32'h0) begin failed++; $display("FAIL wrap_pcplus4 got %h exp 0", PCPlus4); end
        step();
        tests_run++; if (PC !== 32'h0) begin failed++; $display("FAIL wrap_pc got %h exp 0", PC); end
        rst        = 1'b0;
        upd_en     = 1'b1;
        upd_pc     = 32'h20;
        upd_target = 32'h80;
        upd_taken  = 1'b1;
        step();
        rst    = 1'b1;
        upd_en = 1'b0;
        tests_run++; if (PC !== 32'h100) begin failed++; $display("FAIL midreset_pc got %h exp %h", PC, 32'h100); end
        go_to(32'h60);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL midreset_60 got %b exp 0", pred_taken); end
        go_to(32'h40);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL midreset_40 got %b exp 0", pred_taken); end
        go_to(32'h20);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL midreset_20 got %b exp 0", pred_taken); end
        go_to(32'h8);
        tests_run++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL midreset_08 got %b exp 0", pred_taken); end
    endtask

    initial begin
        rst             = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        upd_en          = 1'b0;
        upd_pc          = 32'h0;
        upd_target      = 32'h0;
        upd_taken       = 1'b0;
        #1;
        test_reset();
        test_stall_redirect();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_back_to_back();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
